spram_tester: RTL



---
 rtl/spram_tester_pkg.sv | 22 ++
 rtl/spram_tester_if.sv | 26 ++
 rtl/spram_tester_cmp.sv | 61 ++++++
 rtl/spram_tester.sv | 95 +++++++++
 4 files changed

// File: rtl/spram_tester_pkg.sv
// Shared types and helpers for the SPRAM built-in self-test.
// State encoding and the address-to-pattern function live here.
package spram_tester_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic [DATA_W-1:0] pat(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] key
  );
    return a ^ key;
  endfunction

endpackage

// File: rtl/spram_tester_if.sv
// SPRAM port bundle: address/write side from the tester,
// registered read data back from the memory.
interface spram_tester_if #(
  parameter int ADDR_W = 17
);
  import spram_tester_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              wren;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr,
    output wren,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wren,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/spram_tester_cmp.sv
// One-cycle readback compare: registers the issued address,
// checks returning data, keeps error count and first-error address.
module spram_tester_cmp
  import spram_tester_pkg::*;
#(
  parameter int          ADDR_W  = 17,
  parameter logic [15:0] XOR_KEY = 16'hA5A5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              issue,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              mis;

  always_comb begin
    vld_d   = issue & ~clr;
    addr_d  = addr;
    exp_d   = pat(16'(addr), XOR_KEY);
    err_d   = err_q;
    first_d = first_q;
    mis     = vld_q && (rdata != exp_q);
    if (clr) begin
      err_d   = '0;
      first_d = '0;
    end else if (mis) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0) first_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      addr_q  <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: rtl/spram_tester.sv
// SPRAM BIST sequencer: fill with addr^key, read back, report.
// Compare pipeline and error bookkeeping sit in spram_tester_cmp.
module spram_tester
  import spram_tester_pkg::*;
#(
  parameter int          ADDR_W    = 17,
  parameter int          NUM_WORDS = 16,
  parameter logic [15:0] XOR_KEY   = 16'hA5A5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              go;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    go      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          go      = 1'b1;
          state_d = WRITE;
          addr_d  = '0;
        end
      end
      WRITE: begin
        if (addr_q == LAST) begin
          state_d = READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      READ: begin
        if (addr_q == LAST) begin
          state_d = CHECK;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      CHECK:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wren  = (state_q == WRITE);
  assign mem_wdata = mem_wren ? pat(16'(addr_q), XOR_KEY) : '0;
  assign busy      = (state_q == WRITE) || (state_q == READ)
                  || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_count == 16'd0);

  spram_tester_cmp #(
    .ADDR_W  (ADDR_W),
    .XOR_KEY (XOR_KEY)
  ) u_cmp (
    .clk            (clk),
    .rst_n          (resetn),
    .clr            (go),
    .issue          (state_q == READ),
    .addr           (addr_q),
    .rdata          (mem_rdata),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule
